// File: rtl/mod_addsub_seq_pkg.sv
// Shared types and constants for the sequential modular add/subtract block.
package mod_addsub_pkg;

  localparam int unsigned ADD_W    = 514;
  localparam int unsigned LAT_FULL = 5;
  localparam int unsigned LAT_SKIP = 3;

  typedef enum logic [2:0] {
    StIdle,
    StIssue1,
    StWait1,
    StIssue2,
    StWait2,
    StFin
  } addsub_state_e;

endpackage

// File: rtl/mod_addsub_seq_if.sv
// Request/response bundle of mod_addsub_seq: operands and op select in, result and status out.
interface mod_addsub_seq_if;
  import mod_addsub_pkg::*;

  logic             start;
  logic             subtract;
  logic [ADD_W-1:0] a;
  logic [ADD_W-1:0] b;
  logic [ADD_W-1:0] m;
  logic [ADD_W-1:0] result;
  logic             done;
  logic             busy;

  modport master (
    output start, subtract, a, b, m,
    input  result, done, busy
  );

  modport slave (
    input  start, subtract, a, b, m,
    output result, done, busy
  );

endinterface

// File: rtl/mod_addsub_seq_mpadder.sv
// Registered wide adder/subtractor: one cycle after start, result holds a+b or a-b with
// the carry/borrow in the top bit.
module mpadder #(
  parameter int unsigned W = 514
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W:0]   result
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      result <= '0;
    end else if (start) begin
      result <= subtract ? ({1'b0, in_a} - {1'b0, in_b}) : ({1'b0, in_a} + {1'b0, in_b});
    end
  end

endmodule

// File: rtl/mod_addsub_seq.sv
// Sequential (A +/- B) mod M built from two time-multiplexed passes through one mpadder.
module mod_addsub_seq
  import mod_addsub_pkg::*;
#(
  parameter bit FIXED_LATENCY = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mod_addsub_seq_if.slave  bus
);

  addsub_state_e    state_q, state_d;
  logic [ADD_W-1:0] a_q, b_q, m_q;
  logic             sub_q;
  logic [ADD_W:0]   r1_q;
  logic [ADD_W-1:0] result_q;

  logic             add_start;
  logic             add_sub;
  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_b;
  logic [ADD_W:0]   add_res;
  logic             skip;
  logic [ADD_W-1:0] sel;

  // The adder's own output register serves as R2; it is cleared by the same reset.
  mpadder #(
    .W(ADD_W)
  ) u_mpadder (
    .clk     (clk),
    .resetn  (~rst),
    .start   (add_start),
    .subtract(add_sub),
    .in_a    (add_a),
    .in_b    (add_b),
    .result  (add_res)
  );

  // A subtract without borrow is already reduced, so the second pass can be skipped.
  assign skip = !FIXED_LATENCY && sub_q && !add_res[ADD_W];

  // Second pass is R1-M for add (keep R1 on borrow) or R1+M for subtract (use only if A<B).
  always_comb begin
    if (sub_q) begin
      sel = r1_q[ADD_W] ? add_res[ADD_W-1:0] : r1_q[ADD_W-1:0];
    end else begin
      sel = add_res[ADD_W] ? r1_q[ADD_W-1:0] : add_res[ADD_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    add_start = 1'b0;
    add_sub   = 1'b0;
    add_a     = a_q;
    add_b     = b_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StIssue1;
      end
      StIssue1: begin
        add_start = 1'b1;
        add_sub   = sub_q;
        state_d   = StWait1;
      end
      StWait1: begin
        state_d = skip ? StFin : StIssue2;
      end
      StIssue2: begin
        add_start = 1'b1;
        add_sub   = !sub_q;
        add_a     = r1_q[ADD_W-1:0];
        add_b     = m_q;
        state_d   = StWait2;
      end
      StWait2: begin
        state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      sub_q    <= 1'b0;
      r1_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.start) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        m_q   <= bus.m;
        sub_q <= bus.subtract;
      end
      if (state_q == StWait1) begin
        r1_q <= add_res;
        if (skip) result_q <= add_res[ADD_W-1:0];
      end
      if (state_q == StWait2) result_q <= sel;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = (state_q == StFin);
  assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Scoreboard bench for mod_addsub_seq: full-latency and skip-capable instances run the same
// stimulus; each done is checked against a reference model and the expected latency.
module tb_mod_addsub_seq;
  import mod_addsub_pkg::*;

  typedef struct {
    logic [ADD_W-1:0] res;
    int               lat;
    int               t0;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t q_fl[$];
  exp_t q_sk[$];

  mod_addsub_seq_if bus_fl();
  mod_addsub_seq_if bus_sk();

  mod_addsub_seq #(
    .FIXED_LATENCY(1'b1)
  ) u_dut_fl (
    .clk(clk),
    .rst(rst),
    .bus(bus_fl)
  );

  mod_addsub_seq #(
    .FIXED_LATENCY(1'b0)
  ) u_dut_sk (
    .clk(clk),
    .rst(rst),
    .bus(bus_sk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [ADD_W:0] got, input logic [ADD_W:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [ADD_W-1:0] model(input logic sub, input logic [ADD_W-1:0] a,
                                             input logic [ADD_W-1:0] b,
                                             input logic [ADD_W-1:0] m);
    logic [ADD_W+1:0] s;
    if (!sub) begin
      s = {2'b00, a} + {2'b00, b};
      if (s >= {2'b00, m}) s = s - {2'b00, m};
    end else if (a >= b) begin
      s = {2'b00, a} - {2'b00, b};
    end else begin
      s = {2'b00, a} + {2'b00, m} - {2'b00, b};
    end
    return s[ADD_W-1:0];
  endfunction

  task automatic drive(input logic st, input logic sub, input logic [ADD_W-1:0] a,
                       input logic [ADD_W-1:0] b, input logic [ADD_W-1:0] m);
    bus_fl.start = st; bus_fl.subtract = sub; bus_fl.a = a; bus_fl.b = b; bus_fl.m = m;
    bus_sk.start = st; bus_sk.subtract = sub; bus_sk.a = a; bus_sk.b = b; bus_sk.m = m;
  endtask

  task automatic push(input logic sub, input logic [ADD_W-1:0] a, input logic [ADD_W-1:0] b,
                      input logic [ADD_W-1:0] m, input int t0);
    exp_t e;
    e.res = model(sub, a, b, m);
    e.t0  = t0;
    e.lat = int'(LAT_FULL);
    q_fl.push_back(e);
    if (sub && a >= b) e.lat = int'(LAT_SKIP);
    q_sk.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus_fl.busy || bus_sk.busy) && n < 100);
    if (n >= 100) check("idle_timeout", {514'd0, bus_fl.busy | bus_sk.busy}, '0);
  endtask

  // Returns at the negedge after the start pulse; t0 is the drive-cycle reference.
  task automatic op(input logic sub, input logic [ADD_W-1:0] a, input logic [ADD_W-1:0] b,
                    input logic [ADD_W-1:0] m);
    wait_idle();
    drive(1'b1, sub, a, b, m);
    push(sub, a, b, m, cyc);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_fl.done) begin
      if (q_fl.size() == 0) begin
        check("fl_spurious_done", {514'd0, bus_fl.done}, '0);
      end else begin
        e = q_fl.pop_front();
        check("fl_result", {1'b0, bus_fl.result}, {1'b0, e.res});
        check("fl_latency", ADD_W'(cyc - e.t0), ADD_W'(e.lat));
      end
    end
    if (bus_sk.done) begin
      if (q_sk.size() == 0) begin
        check("sk_spurious_done", {514'd0, bus_sk.done}, '0);
      end else begin
        e = q_sk.pop_front();
        check("sk_result", {1'b0, bus_sk.result}, {1'b0, e.res});
        check("sk_latency", ADD_W'(cyc - e.t0), ADD_W'(e.lat));
      end
    end
  end

  logic [ADD_W-1:0] big_m, ra, rb, rm;
  int               k;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_result_fl", {1'b0, bus_fl.result}, '0);
    check("rst_busy_fl", {514'd0, bus_fl.busy}, '0);
    check("rst_done_fl", {514'd0, bus_fl.done}, '0);
    check("rst_result_sk", {1'b0, bus_sk.result}, '0);
    check("rst_busy_sk", {514'd0, bus_sk.busy}, '0);
    rst = 1'b0;
    @(negedge clk);

    op(1'b0, 514'd7, 514'd9, 514'd13);
    op(1'b0, 514'd3, 514'd4, 514'd13);
    op(1'b0, 514'd6, 514'd7, 514'd13);
    op(1'b1, 514'd3, 514'd9, 514'd13);
    op(1'b1, 514'd9, 514'd3, 514'd13);
    op(1'b1, 514'd5, 514'd5, 514'd13);

    big_m = {1'b0, {513{1'b1}}};
    op(1'b0, big_m - 1, big_m - 1, big_m);
    op(1'b1, '0, big_m - 1, big_m);

    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 17; w++) begin
        rm[w*32 +: 32] = $urandom;
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rm[ADD_W-1] = 1'b0;
      if (rm == '0) rm = 514'd1;
      ra = ra % rm;
      rb = rb % rm;
      op(i[0], ra, rb, rm);
    end

    // Start re-pulsed mid-operation must be ignored.
    op(1'b0, 514'd10, 514'd11, 514'd13);
    @(negedge clk);
    check("busy_mid_op", {514'd0, bus_fl.busy}, 515'd1);
    drive(1'b1, 1'b1, 514'd1, 514'd2, 514'd7);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);

    // Start held through FIN is ignored there and accepted in the next IDLE cycle.
    wait_idle();
    drive(1'b1, 1'b0, 514'd12, 514'd12, 514'd13);
    k = cyc;
    push(1'b0, 514'd12, 514'd12, 514'd13, k);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);
    while (cyc < k + 5) @(negedge clk);
    check("fin_done_fl", {514'd0, bus_fl.done}, 515'd1);
    drive(1'b1, 1'b0, 514'd2, 514'd3, 514'd13);
    push(1'b0, 514'd2, 514'd3, 514'd13, k + 6);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);

    // Reset mid-operation aborts with no done.
    op(1'b0, 514'd1, 514'd1, 514'd13);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    void'(q_fl.pop_back());
    void'(q_sk.pop_back());
    @(negedge clk);
    check("abort_busy_fl", {514'd0, bus_fl.busy}, '0);
    check("abort_result_fl", {1'b0, bus_fl.result}, '0);
    check("abort_done_fl", {514'd0, bus_fl.done}, '0);
    check("abort_busy_sk", {514'd0, bus_sk.busy}, '0);
    check("abort_result_sk", {1'b0, bus_sk.result}, '0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    op(1'b1, 514'd4, 514'd11, 514'd13);

    wait_idle();
    repeat (6) @(negedge clk);
    check("pending_fl", ADD_W'(q_fl.size()), '0);
    check("pending_sk", ADD_W'(q_sk.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
